// File: rtl/spi_resp_pkg.sv
// Shared sizing helpers for the SPI response snapshot FIFO.
// The optional SPI_RESP_PARITY_EN build widens each entry by one parity bit per device.
package spi_resp_pkg;

  localparam int SEQ_W  = 8;
  localparam int DROP_W = 16;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int std_regs(input int std_w, input int w);
    return ceil_div(std_w, w);
  endfunction

  function automatic int dev_regs(input int dev_w, input int w);
    return ceil_div(dev_w, w);
  endfunction

  // Entry layout, LSB first: std frame, chain frames, sequence tag, [parity flags].
  function automatic int entry_width(input int std_w, input int n_dev, input int dev_w);
`ifdef SPI_RESP_PARITY_EN
    return std_w + n_dev * dev_w + SEQ_W + n_dev;
`else
    return std_w + n_dev * dev_w + SEQ_W;
`endif
  endfunction

endpackage

// File: rtl/spi_resp_word_unpack.sv
// Zero-extends a packed frame field up to a whole number of W-bit register words.
module spi_resp_word_unpack
  import spi_resp_pkg::*;
#(
  parameter int W       = 32,
  parameter int FIELD_W = 60,
  localparam int REGS   = ceil_div(FIELD_W, W)
) (
  input  logic [FIELD_W-1:0] field_i,
  output logic [REGS*W-1:0]  words_o
);

  generate
    if (REGS * W > FIELD_W) begin : g_pad
      assign words_o = {{(REGS * W - FIELD_W){1'b0}}, field_i};
    end else begin : g_exact
      assign words_o = field_i;
    end
  endgenerate

endmodule

// File: rtl/spi_resp_snapshot_fifo.sv
// Snapshot FIFO for completed SPI responses with registered first-word-fall-through head.
// Define SPI_RESP_PARITY_EN to add per-device odd-parity error flags (chain_par_err).
module spi_resp_snapshot_fifo
  import spi_resp_pkg::*;
#(
  parameter int W            = 32,
  parameter int STD_W        = 60,
  parameter int N_DEV        = 4,
  parameter int DEV_W        = 48,
  parameter int DEPTH        = 4,
  parameter int OVF_DROP_OLD = 0,
  localparam int STD_REGS    = std_regs(STD_W, W),
  localparam int DEV_REGS    = dev_regs(DEV_W, W),
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                       aclk,
  input  logic                       a_rst,
  input  logic                       resp_valid,
  input  logic [STD_W-1:0]           std_rx,
  input  logic [N_DEV*DEV_W-1:0]     chain_rx,
  input  logic                       pop,
  input  logic                       ovf_clr,
  output logic                       head_valid,
  output logic [STD_REGS*W-1:0]      std_ro_data,
  output logic [N_DEV*DEV_REGS*W-1:0] chain_ro_data,
  output logic [SEQ_W-1:0]           head_seq,
  output logic [LVL_W-1:0]           level,
`ifdef SPI_RESP_PARITY_EN
  output logic [N_DEV-1:0]           chain_par_err,
`endif
  output logic                       ovf_sticky,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CHAIN_W = N_DEV * DEV_W;
  localparam int ENT_W   = entry_width(STD_W, N_DEV, DEV_W);
  localparam int SEQ_LSB = STD_W + CHAIN_W;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic [SEQ_W-1:0]  seq_q;
  logic [ENT_W-1:0]  head_q, head_d, new_entry;
  logic              head_valid_q, sticky_q;
  logic [DROP_W-1:0] drop_q;
  logic              full, do_pop, overflow, do_write;

`ifdef SPI_RESP_PARITY_EN
  logic [N_DEV-1:0] par_err;

  always_comb begin
    par_err = '0;
    for (int i = 0; i < N_DEV; i++) begin
      par_err[i] = ~^chain_rx[i*DEV_W +: DEV_W];
    end
  end

  assign new_entry = {par_err, seq_q, chain_rx, std_rx};
`else
  assign new_entry = {seq_q, chain_rx, std_rx};
`endif

  // When full without a pop, the drop-old policy still writes: the slot under
  // the write pointer is the oldest one, so the read pointer steps past it.
  always_comb begin
    full     = (count_q == LVL_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    overflow = resp_valid && full && !do_pop;
    do_write = resp_valid && (!overflow || (OVF_DROP_OLD != 0));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop || (overflow && (OVF_DROP_OLD != 0))) rd_ptr_d = rd_ptr_q + 1'b1;
    if (resp_valid && !full && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !resp_valid) count_d = count_q - 1'b1;

    head_d = head_q;
    if (count_d != '0) begin
      head_d = (do_write && (wr_ptr_q == rd_ptr_d)) ? new_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge aclk) begin
    if (!a_rst && do_write) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge aclk) begin
    if (a_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      sticky_q     <= 1'b0;
      drop_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_q + SEQ_W'(resp_valid);
      head_q       <= head_d;
      head_valid_q <= (count_d != '0);
      // A clear coinciding with an overflow leaves exactly that one loss counted.
      if (overflow) begin
        sticky_q <= 1'b1;
        if (ovf_clr) drop_q <= DROP_W'(1);
        else if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
      end else if (ovf_clr) begin
        sticky_q <= 1'b0;
        drop_q   <= '0;
      end
    end
  end

  spi_resp_word_unpack #(.W(W), .FIELD_W(STD_W)) u_std_unpack (
    .field_i (head_q[STD_W-1:0]),
    .words_o (std_ro_data)
  );

  generate
    for (genvar i = 0; i < N_DEV; i++) begin : g_dev
      spi_resp_word_unpack #(.W(W), .FIELD_W(DEV_W)) u_dev_unpack (
        .field_i (head_q[STD_W + i*DEV_W +: DEV_W]),
        .words_o (chain_ro_data[i*DEV_REGS*W +: DEV_REGS*W])
      );
    end
  endgenerate

  assign head_valid = head_valid_q;
  assign head_seq   = head_q[SEQ_LSB +: SEQ_W];
  assign level      = count_q;
  assign ovf_sticky = sticky_q;
  assign drop_cnt   = drop_q;
`ifdef SPI_RESP_PARITY_EN
  assign chain_par_err = head_q[ENT_W-1 -: N_DEV];
`endif

endmodule

// File: tb/tb_spi_resp_snapshot_fifo.sv
// Self-checking bench: drop-newest (index 0) and overwrite-oldest (index 1) instances
// share stimulus and are compared against a queue-based reference model.
module tb_spi_resp_snapshot_fifo;

  localparam int W        = 32;
  localparam int STD_W    = 60;
  localparam int N_DEV    = 4;
  localparam int DEV_W    = 48;
  localparam int DEPTH    = 4;
  localparam int STD_REGS = 2;
  localparam int DEV_REGS = 2;
  localparam int CH_W     = N_DEV * DEV_W;
  localparam int STDO_W   = STD_REGS * W;
  localparam int CHO_W    = N_DEV * DEV_REGS * W;

  typedef struct packed {
    logic [STD_W-1:0] std;
    logic [CH_W-1:0]  chain;
    logic [7:0]       seq;
  } ent_t;

  logic             aclk = 1'b0;
  logic             a_rst = 1'b1;
  logic             resp_valid = 1'b0;
  logic [STD_W-1:0] std_rx = '0;
  logic [CH_W-1:0]  chain_rx = '0;
  logic             pop = 1'b0;
  logic             ovf_clr = 1'b0;

  logic              hv [2];
  logic [STDO_W-1:0] stdo [2];
  logic [CHO_W-1:0]  cho [2];
  logic [7:0]        hseq [2];
  logic [2:0]        lvl [2];
  logic              sticky [2];
  logic [15:0]       drop [2];
`ifdef SPI_RESP_PARITY_EN
  logic [N_DEV-1:0]  par [2];
`endif

  int nCompared = 0;
  int nMismatched = 0;

  ent_t        mq [2][$];
  ent_t        mHead [2];
  logic [15:0] mDrop [2];
  logic        mSticky [2];
  logic [7:0]  mSeq;

  always #5 aclk = ~aclk;

  spi_resp_snapshot_fifo #(.W(W), .STD_W(STD_W), .N_DEV(N_DEV), .DEV_W(DEV_W),
                           .DEPTH(DEPTH), .OVF_DROP_OLD(0)) dut0 (
    .aclk(aclk), .a_rst(a_rst), .resp_valid(resp_valid), .std_rx(std_rx),
    .chain_rx(chain_rx), .pop(pop), .ovf_clr(ovf_clr), .head_valid(hv[0]),
    .std_ro_data(stdo[0]), .chain_ro_data(cho[0]), .head_seq(hseq[0]),
    .level(lvl[0]),
`ifdef SPI_RESP_PARITY_EN
    .chain_par_err(par[0]),
`endif
    .ovf_sticky(sticky[0]), .drop_cnt(drop[0])
  );

  spi_resp_snapshot_fifo #(.W(W), .STD_W(STD_W), .N_DEV(N_DEV), .DEV_W(DEV_W),
                           .DEPTH(DEPTH), .OVF_DROP_OLD(1)) dut1 (
    .aclk(aclk), .a_rst(a_rst), .resp_valid(resp_valid), .std_rx(std_rx),
    .chain_rx(chain_rx), .pop(pop), .ovf_clr(ovf_clr), .head_valid(hv[1]),
    .std_ro_data(stdo[1]), .chain_ro_data(cho[1]), .head_seq(hseq[1]),
    .level(lvl[1]),
`ifdef SPI_RESP_PARITY_EN
    .chain_par_err(par[1]),
`endif
    .ovf_sticky(sticky[1]), .drop_cnt(drop[1])
  );

  function automatic logic [STDO_W-1:0] expStd(input ent_t h);
    logic [STDO_W-1:0] r = '0;
    r[STD_W-1:0] = h.std;
    return r;
  endfunction

  function automatic logic [CHO_W-1:0] expChain(input ent_t h);
    logic [CHO_W-1:0] r = '0;
    for (int i = 0; i < N_DEV; i++) r[i*DEV_REGS*W +: DEV_W] = h.chain[i*DEV_W +: DEV_W];
    return r;
  endfunction

  function automatic logic [N_DEV-1:0] expPar(input ent_t h);
    logic [N_DEV-1:0] r = '0;
    for (int i = 0; i < N_DEV; i++) r[i] = ~^h.chain[i*DEV_W +: DEV_W];
    return r;
  endfunction

  // Drives one cycle of inputs, clocks it, then advances the reference model.
  task automatic applyStimulus(input logic rv, input logic [STD_W-1:0] s,
                               input logic [CH_W-1:0] c, input logic p,
                               input logic clr, input logic rst);
    ent_t e;
    bit   popped, ovf;
    resp_valid = rv; std_rx = s; chain_rx = c; pop = p; ovf_clr = clr; a_rst = rst;
    @(posedge aclk);
    #1;
    resp_valid = 1'b0; pop = 1'b0; ovf_clr = 1'b0; a_rst = 1'b0;
    e.std = s; e.chain = c; e.seq = mSeq;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mHead[k] = '0; mDrop[k] = '0; mSticky[k] = 1'b0;
      end else begin
        popped = p && (mq[k].size() > 0);
        ovf    = rv && (mq[k].size() == DEPTH) && !popped;
        if (popped) void'(mq[k].pop_front());
        if (rv) begin
          if (ovf && k == 1) void'(mq[k].pop_front());
          if (!ovf || k == 1) mq[k].push_back(e);
        end
        if (ovf) begin
          mSticky[k] = 1'b1;
          if (clr) mDrop[k] = 16'd1;
          else if (mDrop[k] != 16'hFFFF) mDrop[k] = mDrop[k] + 16'd1;
        end else if (clr) begin
          mSticky[k] = 1'b0; mDrop[k] = '0;
        end
        if (mq[k].size() > 0) mHead[k] = mq[k][0];
      end
    end
    mSeq = rst ? 8'd0 : mSeq + 8'(rv);
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (hv[k] !== 1'b0 || lvl[k] !== 3'd0 || hseq[k] !== 8'd0 || stdo[k] !== '0 ||
          cho[k] !== '0 || sticky[k] !== 1'b0 || drop[k] !== 16'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset[%0d]: got hv=%b lvl=%0d seq=%0d std=%h sticky=%b drop=%0d, expected all zero",
                 k, hv[k], lvl[k], hseq[k], stdo[k], sticky[k], drop[k]);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [CH_W-1:0] c = '0;
    c[DEV_W-1:0] = 48'h111122223333;
    applyStimulus(1'b1, 60'hABCDEF012345678, c, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (hv[0] !== 1'b1 || lvl[0] !== 3'd1 || hseq[0] !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL single_ctrl: got hv=%b lvl=%0d seq=%0d, expected 1/1/0", hv[0], lvl[0], hseq[0]);
    end
    nCompared++;
    if (stdo[0] !== 64'h0ABCDEF0_12345678) begin
      nMismatched++;
      $display("[TB] FAIL single_std: got %h expected 0abcdef012345678", stdo[0]);
    end
    nCompared++;
    if (cho[0][63:0] !== 64'h00001111_22223333) begin
      nMismatched++;
      $display("[TB] FAIL single_dev0: got %h expected 0000111122223333", cho[0][63:0]);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    nCompared++;
    if (hv[0] !== 1'b0 || lvl[0] !== 3'd0 || stdo[0] !== 64'h0ABCDEF0_12345678) begin
      nMismatched++;
      $display("[TB] FAIL single_hold: got hv=%b lvl=%0d std=%h, expected 0/0/held data", hv[0], lvl[0], stdo[0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 60'(n + 1), CH_W'($urandom), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (lvl[k] !== 3'd4 || drop[k] !== 16'd1 || sticky[k] !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL ovf_state[%0d]: got lvl=%0d drop=%0d sticky=%b, expected 4/1/1", k, lvl[k], drop[k], sticky[k]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 2; k++) begin
        want = 8'(n + k);
        nCompared++;
        if (hv[k] !== 1'b1 || hseq[k] !== want || stdo[k] !== 64'(n + k + 1)) begin
          nMismatched++;
          $display("[TB] FAIL ovf_order[%0d]: got hv=%b seq=%0d std=%h, expected 1/%0d/%0d", k, hv[k], hseq[k], stdo[k], want, n + k + 1);
        end
      end
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (hv[k] !== 1'b0 || lvl[k] !== 3'd0) begin
        nMismatched++;
        $display("[TB] FAIL ovf_drain[%0d]: got hv=%b lvl=%0d, expected 0/0", k, hv[k], lvl[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) applyStimulus(1'b1, 60'(n), '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 60'h55, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (lvl[k] !== 3'd4 || sticky[k] !== 1'b0 || drop[k] !== 16'd0 || hseq[k] !== 8'd1) begin
        nMismatched++;
        $display("[TB] FAIL push_pop_full[%0d]: got lvl=%0d sticky=%b drop=%0d seq=%0d, expected 4/0/0/1",
                 k, lvl[k], sticky[k], drop[k], hseq[k]);
      end
    end
  endtask

  task automatic test_ovf_ctrl();
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (sticky[k] !== 1'b1 || drop[k] !== 16'd1) begin
        nMismatched++;
        $display("[TB] FAIL clr_with_ovf[%0d]: got sticky=%b drop=%0d, expected 1/1", k, sticky[k], drop[k]);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (sticky[k] !== 1'b0 || drop[k] !== 16'd0 || lvl[k] !== 3'd4) begin
        nMismatched++;
        $display("[TB] FAIL clr_alone[%0d]: got sticky=%b drop=%0d lvl=%0d, expected 0/0/4", k, sticky[k], drop[k], lvl[k]);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (lvl[k] !== 3'd0 || hv[k] !== 1'b0 || hseq[k] !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL empty_pop[%0d]: got lvl=%0d hv=%b seq=%0d, expected 0/0/0", k, lvl[k], hv[k], hseq[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 60'(n + 7), '0, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (lvl[0] !== 3'd3) begin
      nMismatched++;
      $display("[TB] FAIL pre_reset_level: got %0d expected 3", lvl[0]);
    end
    applyStimulus(1'b1, 60'h99, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (lvl[k] !== 3'd0 || hv[k] !== 1'b0 || hseq[k] !== 8'd0 || stdo[k] !== '0) begin
        nMismatched++;
        $display("[TB] FAIL mid_reset[%0d]: got lvl=%0d hv=%b seq=%0d std=%h, expected all zero", k, lvl[k], hv[k], hseq[k], stdo[k]);
      end
    end
    applyStimulus(1'b1, 60'h42, '0, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (hseq[0] !== 8'd0 || stdo[0] !== 64'h42) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_seq: got seq=%0d std=%h, expected 0/42", hseq[0], stdo[0]);
    end
  endtask

`ifdef SPI_RESP_PARITY_EN
  task automatic test_parity();
    logic [CH_W-1:0] c = '0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N_DEV; i++) c[i*DEV_W +: DEV_W] = 48'h1;
    c[2*DEV_W +: DEV_W] = 48'h000000000003;
    applyStimulus(1'b1, '0, c, 1'b0, 1'b0, 1'b0);
    nCompared++;
    if (par[0] !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL parity: got %b expected 0100", par[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic rv, p, clr, rst;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 800; n++) begin
      rv  = ($urandom_range(99) < 55);
      p   = ($urandom_range(99) < 40);
      clr = ($urandom_range(99) < 5);
      rst = ($urandom_range(399) == 0);
      applyStimulus(rv, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    p, clr, rst);
      for (int k = 0; k < 2; k++) begin
        nCompared++;
        if (hv[k] !== (mq[k].size() != 0) || lvl[k] !== 3'(mq[k].size()) || hseq[k] !== mHead[k].seq ||
            stdo[k] !== expStd(mHead[k]) || cho[k] !== expChain(mHead[k]) ||
            sticky[k] !== mSticky[k] || drop[k] !== mDrop[k]) begin
          nMismatched++;
          $display("[TB] FAIL random[%0d] cycle %0d: got hv=%b lvl=%0d seq=%0d sticky=%b drop=%0d std=%h, expected hv=%b lvl=%0d seq=%0d sticky=%b drop=%0d std=%h",
                   k, n, hv[k], lvl[k], hseq[k], sticky[k], drop[k], stdo[k],
                   mq[k].size() != 0, mq[k].size(), mHead[k].seq, mSticky[k], mDrop[k], expStd(mHead[k]));
        end
`ifdef SPI_RESP_PARITY_EN
        nCompared++;
        if (par[k] !== expPar(mHead[k])) begin
          nMismatched++;
          $display("[TB] FAIL random_par[%0d] cycle %0d: got %b expected %b", k, n, par[k], expPar(mHead[k]));
        end
`endif
      end
    end
  endtask

  initial begin
    mSeq = '0;
    for (int k = 0; k < 2; k++) begin
      mHead[k] = '0; mDrop[k] = '0; mSticky[k] = 1'b0;
    end
    repeat (2) @(posedge aclk);
    #1;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_ovf_ctrl();
    test_reset_midstream();
`ifdef SPI_RESP_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
